// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared encodings for the LED pattern engine
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - step-rate prescaler, one tick every CLK_FREQ/STEP_HZ cycles
module led_tick_gen #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int STEP_HZ  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_FREQ / STEP_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Tick spans the whole last count so the step lands on the edge that wraps it.
  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - LED pattern register with serial/parallel load and animation
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int LED_WIDTH = 16,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int STEP_HZ   = 4,
  parameter logic [LED_WIDTH-1:0] RESET_PATTERN = LED_WIDTH'(1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 D,
  input  logic                 LD,
  input  logic                 pl_en,
  input  logic [LED_WIDTH-1:0] pl_data,
  input  logic [1:0]           mode,
  output logic [LED_WIDTH-1:0] led,
  output logic                 tick
);

  logic [LED_WIDTH-1:0] r_pattern;
  dir_e                 r_dir;
  logic                 r_blank;
  mode_e                r_mode_q;

  logic w_mode_chg;
  logic w_tick;

  assign w_mode_chg = (mode != r_mode_q);

  led_tick_gen #(
    .CLK_FREQ(CLK_FREQ),
    .STEP_HZ (STEP_HZ)
  ) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .clr  (w_mode_chg),
    .tick (w_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pattern <= RESET_PATTERN;
      r_dir     <= DIR_LEFT;
      r_blank   <= 1'b0;
      r_mode_q  <= MODE_STATIC;
    end else begin
      if (w_mode_chg) begin
        r_mode_q <= mode_e'(mode);
        r_blank  <= 1'b0;
        r_dir    <= DIR_LEFT;
      end

      // Loads outrank the step; a mode change also cancels the step for this edge.
      if (pl_en) begin
        r_pattern <= pl_data;
      end else if (LD) begin
        r_pattern <= {r_pattern[LED_WIDTH-2:0], D};
      end else if (w_tick && !w_mode_chg) begin
        case (r_mode_q)
          MODE_ROTATE: r_pattern <= {r_pattern[LED_WIDTH-2:0], r_pattern[LED_WIDTH-1]};
          MODE_BOUNCE: begin
            if (r_pattern != '0) begin
              if (r_dir == DIR_LEFT) begin
                if (r_pattern[LED_WIDTH-1]) r_dir <= DIR_RIGHT;
                else                        r_pattern <= r_pattern << 1;
              end else begin
                if (r_pattern[0]) r_dir <= DIR_LEFT;
                else              r_pattern <= r_pattern >> 1;
              end
            end
          end
          MODE_BLINK:  r_blank <= ~r_blank;
          default:     ;
        endcase
      end
    end
  end

  assign led  = r_blank ? '0 : r_pattern;
  assign tick = w_tick;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - randomized bench for led_pattern_engine against a behavioural model
module tb_led_pattern_engine;

  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        D;
  logic        LD;
  logic        pl_en;
  logic [15:0] pl_data;
  logic [1:0]  mode;
  logic [15:0] led;
  logic        tick;

  int vectors     = 0;
  int miscompares = 0;
  int seen_ticks  = 0;

  logic [15:0] m_pat;
  int          m_phase;
  bit          m_right;
  bit          m_blank;
  logic [1:0]  m_mode;

  led_pattern_engine #(
    .LED_WIDTH    (16),
    .CLK_FREQ     (40),
    .STEP_HZ      (10),
    .RESET_PATTERN(16'h0001)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .D      (D),
    .LD     (LD),
    .pl_en  (pl_en),
    .pl_data(pl_data),
    .mode   (mode),
    .led    (led),
    .tick   (tick)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pat   = 16'h0001;
    m_phase = 0;
    m_right = 1'b0;
    m_blank = 1'b0;
    m_mode  = 2'd0;
  endtask

  // Model advances by one clock edge; pattern handled as an integer 0..65535.
  task automatic model_edge(input bit p, input logic [15:0] pv, input bit ld, input bit d,
                            input logic [1:0] md);
    bit fire;
    int v;
    fire = (m_phase == DIV - 1);
    if (md != m_mode) begin
      m_mode  = md;
      m_phase = 0;
      m_blank = 1'b0;
      m_right = 1'b0;
      fire    = 1'b0;
    end else begin
      m_phase = (m_phase + 1) % DIV;
    end
    v = int'(m_pat);
    if (p) begin
      v = int'(pv);
    end else if (ld) begin
      v = (v * 2) % 65536 + int'(d);
    end else if (fire) begin
      case (m_mode)
        2'd1: v = (v * 2) % 65536 + v / 32768;
        2'd2: begin
          if (v != 0) begin
            if (!m_right) begin
              if (v >= 32768) m_right = 1'b1;
              else            v = v * 2;
            end else begin
              if (v % 2 == 1) m_right = 1'b0;
              else            v = v / 2;
            end
          end
        end
        2'd3: m_blank = !m_blank;
        default: ;
      endcase
    end
    m_pat = 16'(v);
  endtask

  task automatic cyc(input bit p = 1'b0, input logic [15:0] pv = 16'h0, input bit ld = 1'b0,
                     input bit d = 1'b0);
    pl_en   = p;
    pl_data = pv;
    LD      = ld;
    D       = d;
    @(negedge clock);
    chk("led", 32'(led), 32'(m_blank ? 16'h0000 : m_pat));
    chk("tick", 32'(tick), 32'(m_phase == DIV - 1));
    if (tick) seen_ticks++;
    @(posedge clock);
    model_edge(p, pv, ld, d, mode);
    #1;
  endtask

  task automatic run_ticks(input int n);
    int start;
    int budget;
    start  = seen_ticks;
    budget = 0;
    while ((seen_ticks - start) < n && budget < 20 * DIV * n) begin
      cyc();
      budget++;
    end
    chk("tick_budget", 32'(seen_ticks - start), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int r;
    reset   = 1'b1;
    D       = 1'b0;
    LD      = 1'b0;
    pl_en   = 1'b0;
    pl_data = 16'h0;
    mode    = 2'd0;
    model_reset();
    #2;
    chk("reset_led", 32'(led), 32'(16'h0001));
    chk("reset_tick", 32'(tick), 32'(1'b0));
    #14;
    reset = 1'b0;

    base = seen_ticks;
    for (int i = 0; i < 12; i++) cyc();
    chk("t1_tick_count", 32'(seen_ticks - base), 32'(3));

    cyc(0, 16'h0, 1, 1);
    cyc(0, 16'h0, 1, 0);
    cyc(0, 16'h0, 1, 1);
    cyc(0, 16'h0, 1, 1);
    chk("t2_serial", 32'(led), 32'(16'h001B));
    run_ticks(2);
    chk("t2_static", 32'(led), 32'(16'h001B));

    mode = 2'd1;
    cyc(1, 16'h8001);
    chk("t3_load", 32'(led), 32'(16'h8001));
    run_ticks(1);
    chk("t3_rot1", 32'(led), 32'(16'h0003));
    run_ticks(1);
    chk("t3_rot2", 32'(led), 32'(16'h0006));
    for (int i = 0; i < DIV && m_phase != DIV - 1; i++) cyc();
    cyc(1, 16'h1234);
    chk("t3_load_on_tick", 32'(led), 32'(16'h1234));
    run_ticks(1);
    chk("t3_rot3", 32'(led), 32'(16'h2468));

    mode = 2'd2;
    cyc(1, 16'h4000);
    run_ticks(1);
    chk("t4_b1", 32'(led), 32'(16'h8000));
    run_ticks(1);
    chk("t4_b2", 32'(led), 32'(16'h8000));
    run_ticks(1);
    chk("t4_b3", 32'(led), 32'(16'h4000));
    run_ticks(1);
    chk("t4_b4", 32'(led), 32'(16'h2000));
    cyc(1, 16'h0000);
    run_ticks(2);
    chk("t4_zero", 32'(led), 32'(16'h0000));
    cyc(1, 16'h8001);
    run_ticks(3);
    chk("t4_both_ends", 32'(led), 32'(16'h8001));

    mode = 2'd3;
    cyc(1, 16'hA5A5);
    run_ticks(1);
    chk("t5_blank", 32'(led), 32'(16'h0000));
    run_ticks(1);
    chk("t5_show", 32'(led), 32'(16'hA5A5));
    run_ticks(1);
    chk("t5_blank2", 32'(led), 32'(16'h0000));
    mode = 2'd0;
    cyc();
    chk("t5_static_unblank", 32'(led), 32'(16'hA5A5));
    base = seen_ticks;
    for (int i = 0; i < 3; i++) cyc();
    chk("t5_restart_quiet", 32'(seen_ticks - base), 32'(0));
    cyc();
    chk("t5_restart_tick", 32'(seen_ticks - base), 32'(1));

    base = seen_ticks;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) mode = mode + 2'd1;
      cyc();
    end
    chk("t6_no_ticks", 32'(seen_ticks - base), 32'(0));
    chk("t6_pattern", 32'(led), 32'(16'hA5A5));

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 15));
      cyc(r == 0, 16'($urandom), (r == 1) || (r == 2), 1'($urandom_range(0, 1)));
    end

    mode = 2'd1;
    cyc(1, 16'h0F0F);
    run_ticks(1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_led", 32'(led), 32'(16'h0001));
    chk("async_reset_tick", 32'(tick), 32'(1'b0));
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    mode  = 2'd0;
    for (int i = 0; i < 8; i++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
